// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and helpers for the nibble-serial multi-precision adder.
package nibble_serial_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Slice index width; a single-slice adder still needs a 1-bit index.
  function automatic int idx_width(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/ripple_carry_lookahead_adder.sv
// 4-bit carry-lookahead adder stage: all carries derived from generate/propagate terms.
module ripple_carry_lookahead_adder (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] Sum,
  output logic       Cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = A & B;
  assign p = A ^ B;

  assign c[0] = Cin;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign Sum  = p ^ c[3:0];
  assign Cout = c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that walks one 4-bit slice per cycle through a single CLA stage,
// carrying between slices in a register; valid/ready on both request and result.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             done_valid,
  input  logic             done_ready
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = idx_width(NIBBLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  if ((WIDTH < NIBBLE_W) || ((WIDTH % NIBBLE_W) != 0)) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
  end

  state_e             state;
  state_e             state_nxt;
  logic [IDX_W-1:0]   idx;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               carry_q;
  logic [WIDTH-1:0]   sum_q;
  logic               cout_q;

  logic [NIBBLE_W-1:0] cla_a;
  logic [NIBBLE_W-1:0] cla_b;
  logic [NIBBLE_W-1:0] cla_sum;
  logic                cla_cout;
  logic                accept;
  logic                last;

  assign accept = (state == IDLE) && start_valid;
  assign last   = (idx == IDX_LAST);

  assign cla_a = a_q[idx*NIBBLE_W +: NIBBLE_W];
  assign cla_b = b_q[idx*NIBBLE_W +: NIBBLE_W];

  ripple_carry_lookahead_adder u_cla (
    .A    (cla_a),
    .B    (cla_b),
    .Cin  (carry_q),
    .Sum  (cla_sum),
    .Cout (cla_cout)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    if (done_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            a_q     <= A;
            b_q     <= B;
            carry_q <= Cin;
            idx     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
          end
        end
        RUN: begin
          sum_q[idx*NIBBLE_W +: NIBBLE_W] <= cla_sum;
          carry_q <= cla_cout;
          // Hold idx on the final slice so it never leaves 0..NIBBLES-1.
          if (last) cout_q <= cla_cout;
          else      idx    <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign start_ready = (state == IDLE);
  assign done_valid  = (state == DONE);
  assign Sum         = sum_q;
  assign Cout        = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder at WIDTH=16 and WIDTH=4.
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_valid, start_ready, Cin, Cout, done_valid, done_ready;
  logic [15:0] A, B, Sum;
  logic        sv4, sr4, cin4, cout4, dv4, dr4;
  logic [3:0]  a4, b4, sum4;

  int vectors = 0;
  int miscompares = 0;
  logic [16:0] exp_q[$];

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
    .A(A), .B(B), .Cin(Cin), .Sum(Sum), .Cout(Cout),
    .done_valid(done_valid), .done_ready(done_ready)
  );

  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv4), .start_ready(sr4),
    .A(a4), .B(b4), .Cin(cin4), .Sum(sum4), .Cout(cout4),
    .done_valid(dv4), .done_ready(dr4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one request and, when asked, record its expected result.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                          input bit push);
    for (int i = 0; i < 20 && !start_ready; i++) tick();
    A = a; B = b; Cin = c; start_valid = 1'b1;
    if (push) exp_q.push_back({1'b0, a} + {1'b0, b} + {16'd0, c});
    tick();
    start_valid = 1'b0;
  endtask

  // Count edges from the accept edge until done_valid; 50 means it never came.
  task automatic wait_done(output int cyc, output bit sr_seen);
    cyc = 0;
    sr_seen = 1'b0;
    while (!done_valid && cyc < 50) begin
      if (start_ready) sr_seen = 1'b1;
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    vectors++;
    if ({Sum, Cout, done_valid} !== 18'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got sum=%h cout=%b dv=%b want 0/0/0", Sum, Cout, done_valid);
    end
    vectors++;
    if ({sum4, cout4, dv4} !== 6'd0) begin
      miscompares++;
      $display("FAIL reset_outputs4: got sum=%h cout=%b dv=%b want 0/0/0", sum4, cout4, dv4);
    end
    rst_n = 1'b1;
    tick();
    vectors++;
    if (start_ready !== 1'b1 || sr4 !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: got %b/%b want 1/1", start_ready, sr4);
    end
  endtask

  // One full operation with done_ready high: latency, ready gating, result, exit.
  task automatic run_check(input string name, input logic [15:0] a, input logic [15:0] b,
                           input logic c, input bit scramble);
    int cyc;
    bit sr_seen;
    logic [16:0] exp;
    start_op(a, b, c, 1'b1);
    if (scramble) begin
      A = 16'hFFFF; B = 16'hFFFF; Cin = 1'b1;
    end
    wait_done(cyc, sr_seen);
    vectors++;
    if (cyc !== 4) begin
      miscompares++;
      $display("FAIL %s_latency: got %0d edges want 4", name, cyc);
    end
    vectors++;
    if (sr_seen) begin
      miscompares++;
      $display("FAIL %s_start_ready_run: got 1 during RUN want 0", name);
    end
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 17'h1XXXX;
    vectors++;
    if ({Cout, Sum} !== exp) begin
      miscompares++;
      $display("FAIL %s_result: got cout=%b sum=%h want cout=%b sum=%h", name, Cout, Sum, exp[16], exp[15:0]);
    end
    vectors++;
    if (start_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_ready_in_done: got %b want 0", name, start_ready);
    end
    tick();
    vectors++;
    if (done_valid !== 1'b0 || start_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_exit: got dv=%b sr=%b want 0/1", name, done_valid, start_ready);
    end
    A = '0; B = '0; Cin = 1'b0;
  endtask

  task automatic test_zero();
    run_check("zero", 16'h0000, 16'h0000, 1'b0, 1'b0);
  endtask

  task automatic test_carry_chain();
    run_check("ffff_p1", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    run_check("a5a5_5a5a_c", 16'hA5A5, 16'h5A5A, 1'b1, 1'b0);
  endtask

  task automatic test_input_change();
    run_check("late_change", 16'h1234, 16'h4321, 1'b1, 1'b1);
  endtask

  task automatic test_backpressure();
    int cyc;
    bit sr_seen;
    logic [16:0] exp;
    done_ready = 1'b0;
    start_op(16'h0F0F, 16'h00F1, 1'b0, 1'b1);
    wait_done(cyc, sr_seen);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 17'h1XXXX;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (done_valid !== 1'b1 || {Cout, Sum} !== exp) begin
        miscompares++;
        $display("FAIL hold_%0d: got dv=%b cout=%b sum=%h want 1/%b/%h", i, done_valid, Cout, Sum, exp[16], exp[15:0]);
      end
      A = 16'h1111; B = 16'h1111; start_valid = 1'b1;
      if (i == 2) begin
        start_valid = 1'b0;
        done_ready = 1'b1;
      end
      tick();
    end
    vectors++;
    if (done_valid !== 1'b0 || start_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL hold_exit: got dv=%b sr=%b want 0/1", done_valid, start_ready);
    end
    run_check("after_hold", 16'h0001, 16'h0002, 1'b0, 1'b0);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL hold_queue: got %0d leftover want 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_run();
    bit seen;
    start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    tick();
    rst_n = 1'b0;
    tick();
    vectors++;
    if ({Sum, Cout, done_valid, start_ready} !== 19'd1) begin
      miscompares++;
      $display("FAIL abort: got sum=%h cout=%b dv=%b sr=%b want 0/0/0/1", Sum, Cout, done_valid, start_ready);
    end
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (done_valid) seen = 1'b1;
      tick();
    end
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL abort_no_done: got done_valid pulse want none");
    end
    run_check("post_abort", 16'h0003, 16'h0003, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++)
      run_check("random", 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
  endtask

  task automatic test_width4();
    int cyc;
    logic [16:0] exp;
    for (int i = 0; i < 20 && !sr4; i++) tick();
    a4 = 4'hF; b4 = 4'h1; cin4 = 1'b0; sv4 = 1'b1;
    exp_q.push_back({12'd0, {1'b0, a4} + {1'b0, b4} + {4'd0, cin4}});
    tick();
    sv4 = 1'b0;
    a4 = 4'h0;
    cyc = 0;
    while (!dv4 && cyc < 50) begin
      tick();
      cyc++;
    end
    vectors++;
    if (cyc !== 1) begin
      miscompares++;
      $display("FAIL w4_latency: got %0d edges want 1", cyc);
    end
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 17'h1XXXX;
    vectors++;
    if ({12'd0, cout4, sum4} !== exp) begin
      miscompares++;
      $display("FAIL w4_result: got cout=%b sum=%h want cout=%b sum=%h", cout4, sum4, exp[4], exp[3:0]);
    end
    tick();
    vectors++;
    if (dv4 !== 1'b0 || sr4 !== 1'b1) begin
      miscompares++;
      $display("FAIL w4_exit: got dv=%b sr=%b want 0/1", dv4, sr4);
    end
  endtask

  initial begin
    rst_n = 1'b0; start_valid = 1'b0; A = '0; B = '0; Cin = 1'b0; done_ready = 1'b1;
    sv4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; dr4 = 1'b1;
    test_reset();
    test_zero();
    test_carry_chain();
    test_input_change();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    test_width4();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
Multi-precision adder front end. Accepts WIDTH-bit operands over a valid/ready handshake and adds them one 4-bit slice per cycle through a single instance of the team's 4-bit ripple_carry_lookahead_adder. The carry is held in a register between slices. It returns the WIDTH-bit Sum and the final Cout over a second valid/ready handshake. It sits directly upstream of, and wraps, the 4-bit CLA stage, trading latency for area on wide adds.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 4 (elaboration error otherwise)
NIBBLES, WIDTH/4, derived localparam; number of RUN cycles

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous, active-low reset, sampled on rising clk edge
start_valid  input  1  operand request valid
start_ready  output  1  block can accept operands
A  input  WIDTH  operand A, sampled only on start handshake
B  input  WIDTH  operand B, sampled only on start handshake
Cin  input  1  carry-in, sampled only on start handshake
Sum  output  WIDTH  result; valid when done_valid=1
Cout  output  1  carry-out of the MSB slice; valid when done_valid=1
done_valid  output  1  result available
done_ready  input  1  consumer accepts result

Behaviour:
- One clock (clk). Reset is synchronous and active-low (rst_n).
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, slice index=0, carry register=0.
  - Operand registers = 0, Sum=0, Cout=0, done_valid=0.
  - start_ready=1 from the first cycle after rst_n deasserts.
- States: IDLE, RUN, DONE.
- IDLE:
  - start_ready=1, done_valid=0.
  - On start_valid & start_ready: latch A, B, Cin into a_q, b_q, carry_q; set idx=0; clear Sum; go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - start_ready=0, done_valid=0.
  - Each cycle, drive the CLA with A=a_q[4*idx+3:4*idx], B=b_q[same slice], Cin=carry_q.
  - At the edge: Sum[4*idx+3:4*idx] <= CLA Sum; carry_q <= CLA Cout; idx <= idx+1.
  - When idx==NIBBLES-1: Cout <= CLA Cout; go to DONE.
  - RUN lasts exactly NIBBLES cycles.
- DONE:
  - done_valid=1, start_ready=0.
  - Sum and Cout hold stable.
  - On done_ready=1, go to IDLE; done_valid drops and start_ready rises on the following cycle.
  - No back-to-back accept from DONE.
- Latency: handshake at edge t. done_valid is first high in the cycle after edge t+NIBBLES, i.e. NIBBLES+1 cycles after the accept cycle. Throughput is one add per NIBBLES+2 cycles with done_ready tied high.
- Arithmetic: {Cout,Sum} = A + B + Cin, modulo 2^(WIDTH+1). No overflow/sign flag.
- Boundaries:
  - start_valid while not IDLE is ignored; it is neither queued nor latched.
  - A, B, Cin changing after acceptance have no effect.
  - done_ready while not in DONE is ignored.
  - WIDTH=4: RUN is one cycle, and the idx wrap is trivial.
  - idx never exceeds NIBBLES-1 and is reset to 0 on each accept.
  - A carry generated in any slice propagates to the next slice via carry_q; a full-width carry chain (e.g. all-ones + 1) must reach Cout.
  - Reset mid-RUN or mid-DONE aborts the operation. All outputs return to reset values at that edge, and no done_valid pulse is produced for the aborted operation.

Decomposition:
- Shared package:
  - state enum typedef {IDLE, RUN, DONE}
  - constant NIBBLE_W=4
  - a function computing the slice index width, $clog2(NIBBLES) with a minimum of 1
- Sub-module: one instance of the existing ripple_carry_lookahead_adder (4-bit, ports A, B, Cin, Sum, Cout).
- FSM, index counter, carry register and slice write-back stay in nibble_serial_adder.

Test Plan:
- WIDTH=16, A=0x0000, B=0x0000, Cin=0, done_ready=1 -> Sum=0x0000, Cout=0. done_valid high exactly 5 cycles after the accept cycle; start_ready low from accept until the cycle after DONE exits.
- A=0xFFFF, B=0x0001, Cin=0 -> Sum=0x0000, Cout=1 (carry traverses all 4 slices). Also A=0xA5A5, B=0x5A5A, Cin=1 -> Sum=0x0000, Cout=1.
- A=0x1234, B=0x4321, Cin=1 -> Sum=0x5556, Cout=0. Change A/B/Cin to 0xFFFF/0xFFFF/1 during RUN -> result unchanged.
- Backpressure: hold done_ready=0 for 3 cycles in DONE -> Sum and Cout stable, done_valid=1. Pulse start_valid with A=B=0x1111 during that window -> ignored. The next accepted op yields only its own result.
- Reset mid-RUN: drive rst_n=0 for 1 cycle at the 2nd RUN cycle of 0xFFFF+0x0001 -> next cycle Sum=0, Cout=0, done_valid=0, start_ready=1. No done_valid appears, and a fresh 0x0003+0x0003 -> Sum=0x0006, Cout=0.
- WIDTH=4 instance: A=0xF, B=0x1, Cin=0 -> Sum=0x0, Cout=1, with done_valid 2 cycles after accept.
